// File: rtl/uart_stream_ctl.sv
// uart_stream_ctl: FIFO-buffered UART echo / periodic "Hello, world!\r\n" sender with valid/ready output.
// Define ECHO_UPCASE_EN to convert echoed 'a'..'z' to uppercase.
module uart_stream_ctl #(
    parameter int FIFO_AW = 4,
    parameter int PERIOD  = 10000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [7:0]       din,
    input  logic             din_valid,
    output logic [7:0]       dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [7:0]       led,
    output logic             overflow,
    output logic [FIFO_AW:0] fifo_count
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TW = $clog2(PERIOD);
    localparam logic [7:0] ROM [15] = '{8'h48, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h2c, 8'h20, 8'h77,
                                        8'h6f, 8'h72, 8'h6c, 8'h64, 8'h21, 8'h0d, 8'h0a};

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state, state_nxt;
    logic [3:0]         idx, idx_nxt;
    logic               act, cur, beat, ld, tick, pop, push, drop, valid_nxt;
    logic [7:0]         data_nxt;
    logic [TW-1:0]      timer;
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wp, rp;

    function automatic logic [7:0] conv(input logic [7:0] b);
`ifdef ECHO_UPCASE_EN
        return (b >= 8'h61 && b <= 8'h7a) ? b - 8'h20 : b;
`else
        return b;
`endif
    endfunction

    // cur is the active mode this cycle: the mode input is only honoured when no beat is pending
    always_comb begin
        beat = dout_valid & dout_ready;
        ld = ~dout_valid | beat;
        cur = ld ? mode : act;
        tick = cur & (timer == TW'(PERIOD - 1));
        pop = ld & ~cur & (fifo_count != '0);
        push = ~cur & din_valid & ((fifo_count != (FIFO_AW + 1)'(DEPTH)) | pop);
        drop = ~cur & din_valid & ~push;
        state_nxt = state;
        idx_nxt = idx;
        valid_nxt = dout_valid;
        data_nxt = dout;
        if (!cur) begin
            state_nxt = IDLE;
            idx_nxt = '0;
            if (ld) begin
                valid_nxt = pop;
                data_nxt = pop ? conv(mem[rp]) : dout;
            end
        end else if (state == IDLE) begin
            if (ld) begin
                state_nxt = tick ? SEND : IDLE;
                valid_nxt = tick;
                data_nxt = tick ? ROM[0] : dout;
            end
        end else if (beat) begin
            state_nxt = (idx == 4'd14) ? IDLE : SEND;
            idx_nxt = (idx == 4'd14) ? 4'd0 : idx + 4'd1;
            valid_nxt = idx != 4'd14;
            data_nxt = (idx == 4'd14) ? dout : ROM[idx_nxt];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            dout <= '0;
            dout_valid <= 1'b0;
            led <= '0;
            overflow <= 1'b0;
            fifo_count <= '0;
            wp <= '0;
            rp <= '0;
            act <= 1'b0;
            timer <= '0;
        end else begin
            state <= state_nxt;
            idx <= idx_nxt;
            dout <= data_nxt;
            dout_valid <= valid_nxt;
            act <= cur;
            timer <= (cur && !tick) ? timer + 1'b1 : '0;
            if (din_valid) led <= din;
            if (drop) overflow <= 1'b1;
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            fifo_count <= fifo_count + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
        end
    end

    always_ff @(posedge clk)
        if (push) mem[wp] <= din;
endmodule

// File: tb/tb_uart_stream_ctl.sv
// tb_uart_stream_ctl: directed stimulus against a queue-based model of uart_stream_ctl (FIFO_AW=2, PERIOD=32).
module tb_uart_stream_ctl;
    localparam int AW = 2;
    localparam int P = 32;

    logic       clk = 0, rst = 0, mode = 0, din_valid = 0, dout_ready = 1;
    logic [7:0] din = 0;
    logic [7:0] dout, led;
    logic       dout_valid, overflow;
    logic [AW:0] fifo_count;

    uart_stream_ctl #(.FIFO_AW(AW), .PERIOD(P)) dut (
        .clk(clk), .rst(rst), .mode(mode), .din(din), .din_valid(din_valid),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .led(led), .overflow(overflow), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    byte unsigned MSG [15] = '{8'h48, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h2c, 8'h20, 8'h77,
                               8'h6f, 8'h72, 8'h6c, 8'h64, 8'h21, 8'h0d, 8'h0a};

    task automatic chk(input string name, input int act_v, input int exp_v);
        checks++;
        if (act_v != exp_v) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act_v, exp_v);
        end
    endtask

    function automatic logic [7:0] up(input logic [7:0] b);
`ifdef ECHO_UPCASE_EN
        return (b >= 8'h61 && b <= 8'h7a) ? b - 8'h20 : b;
`else
        return b;
`endif
    endfunction

    // Model: FIFO as a queue, output slot, message position (-1 = none) and period counter
    byte unsigned mq[$];
    logic [7:0] md = 0, mled = 0;
    bit mv = 0, mov = 0, mam = 0;
    int mt = 0, mpos = -1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            md = 0; mled = 0; mv = 0; mov = 0; mam = 0; mt = 0; mpos = -1;
        end else begin : step
            bit beat, free, m, tk, pp;
            logic [7:0] hd;
            beat = mv && dout_ready;
            free = !mv || beat;
            m = free ? mode : mam;
            tk = m && mt == P - 1;
            pp = free && !m && mq.size() > 0;
            hd = pp ? mq.pop_front() : 8'h00;
            if (din_valid) mled = din;
            if (!m && din_valid) begin
                if (mq.size() < (1 << AW)) mq.push_back(din);
                else mov = 1;
            end
            if (!m) begin
                mpos = -1;
                if (free) begin
                    mv = pp;
                    if (pp) md = up(hd);
                end
            end else if (mpos < 0) begin
                if (tk) begin mpos = 0; mv = 1; md = MSG[0]; end
                else if (free) mv = 0;
            end else if (beat) begin
                mpos++;
                if (mpos == 15) begin mpos = -1; mv = 0; end
                else md = MSG[mpos];
            end
            mt = (m && !tk) ? mt + 1 : 0;
            mam = m;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("dout_valid", dout_valid, mv);
            chk("dout", dout, md);
            chk("led", led, mled);
            chk("overflow", overflow, mov);
            chk("fifo_count", fifo_count, mq.size());
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input int lim, output int n);
        n = 0;
        while (!dout_valid && n < lim) begin
            cyc();
            n++;
        end
        chk("wait_valid", dout_valid, 1);
    endtask

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        byte unsigned got[$];
        byte unsigned ex[$];
        logic [7:0] vals [3];
        int n;
        #1 rst = 1;
        #2;
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_led", led, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_count", fifo_count, 0);
        cyc(); cyc();
        rst = 0;
        cyc();
        // single echo byte
        din = 8'h41; din_valid = 1;
        cyc();
        din_valid = 0;
        chk("echo_count1", fifo_count, 1);
        chk("echo_led", led, 8'h41);
        chk("echo_valid_early", dout_valid, 0);
        cyc();
        chk("echo_valid", dout_valid, 1);
        chk("echo_dout", dout, 8'h41);
        chk("echo_count0", fifo_count, 0);
        cyc();
        chk("echo_valid_once", dout_valid, 0);
        // case conversion
        vals = '{8'h61, 8'h7a, 8'h5b};
        got.delete();
        for (int i = 0; i < 10; i++) begin
            din_valid = i < 3;
            if (i < 3) din = vals[i];
            if (dout_valid && dout_ready) got.push_back(dout);
            cyc();
        end
        din_valid = 0;
`ifdef ECHO_UPCASE_EN
        ex = '{8'h41, 8'h5a, 8'h5b};
`else
        ex = '{8'h61, 8'h7a, 8'h5b};
`endif
        chk("case_len", got.size(), 3);
        for (int i = 0; i < 3; i++) chk("case_byte", (i < got.size()) ? got[i] : -1, ex[i]);
        // overflow with stalled transmitter, then push+pop on full FIFO
        dout_ready = 0;
        for (int i = 0; i < 6; i++) begin
            din_valid = 1; din = 8'h10 + 8'(i);
            cyc();
        end
        din_valid = 0;
        chk("ovf_count", fifo_count, 4);
        chk("ovf_flag", overflow, 1);
        chk("ovf_dout", dout, 8'h10);
        chk("ovf_valid", dout_valid, 1);
        got.delete();
        dout_ready = 1; din_valid = 1; din = 8'h16;
        if (dout_valid && dout_ready) got.push_back(dout);
        cyc();
        din_valid = 0;
        chk("full_pushpop_count", fifo_count, 4);
        for (int i = 0; i < 8; i++) begin
            if (dout_valid && dout_ready) got.push_back(dout);
            cyc();
        end
        ex = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h16};
        chk("drain_len", got.size(), 6);
        for (int i = 0; i < 6; i++) chk("drain_byte", (i < got.size()) ? got[i] : -1, ex[i]);
        chk("ovf_sticky", overflow, 1);
        // asynchronous reset mid-operation
        dout_ready = 0;
        din_valid = 1; din = 8'h20;
        cyc();
        din = 8'h21;
        cyc();
        din_valid = 0;
        cyc();
        #1 rst = 1;
        #1;
        chk("arst_valid", dout_valid, 0);
        chk("arst_dout", dout, 0);
        chk("arst_count", fifo_count, 0);
        chk("arst_overflow", overflow, 0);
        chk("arst_led", led, 0);
        cyc();
        rst = 0; dout_ready = 1;
        cyc();
        // send mode: first tick PERIOD cycles after entering
        mode = 1;
        wait_valid(40, n);
        chk("first_tick_latency", n, 32);
        for (int i = 0; i < 15; i++) begin
            chk("msg_valid", dout_valid, 1);
            chk("msg_byte", dout, MSG[i]);
            cyc();
        end
        chk("msg_end", dout_valid, 0);
        wait_valid(40, n);
        chk("period_gap", n, 17);
        // backpressure
        got.delete();
        for (int i = 0; i < 80 && got.size() < 15; i++) begin
            dout_ready = (i % 2) == 1;
            if (dout_valid && dout_ready) got.push_back(dout);
            cyc();
        end
        dout_ready = 1;
        chk("bp_len", got.size(), 15);
        for (int i = 0; i < 15; i++) chk("bp_byte", (i < got.size()) ? got[i] : -1, MSG[i]);
        // mode switch mid-message
        wait_valid(40, n);
        chk("ms_first", dout, 8'h48);
        repeat (4) cyc();
        chk("ms_o", dout, 8'h6f);
        dout_ready = 0; mode = 0;
        din_valid = 1; din = 8'h55;
        cyc();
        din_valid = 0;
        chk("send_led", led, 8'h55);
        chk("send_no_push", fifo_count, 0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("ms_hold_valid", dout_valid, 1);
            chk("ms_hold_dout", dout, 8'h6f);
        end
        dout_ready = 1;
        cyc();
        chk("ms_abort", dout_valid, 0);
        repeat (3) cyc();
        mode = 1;
        wait_valid(40, n);
        chk("ms_restart", dout, 8'h48);
        chk("ms_restart_latency", n, 32);
        repeat (3) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_stream_ctl.md
# uart_stream_ctl

Byte-stream controller between the UART receiver and the UART transmitter. It runs in one of two modes. In echo mode, received bytes are buffered in a FIFO and echoed back. In send mode, it emits the fixed message "Hello, world!\r\n" once per programmable period. It replaces the unbuffered strobe-based controller with a valid/ready handshake toward the transmitter, a parametrised FIFO, overflow reporting, and safe mode switching.

## Interface
- FIFO_AW, 4: FIFO address width; depth = 2**FIFO_AW bytes.
- PERIOD, 10000000: clock cycles between message starts in send mode; must be ≥ 16.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- mode  input  1  0 = echo, 1 = send.
- din  input  8  received byte.
- din_valid  input  1  one-cycle strobe per received byte.
- dout  output  8  byte to transmitter.
- dout_valid  output  1  dout holds a byte awaiting acceptance.
- dout_ready  input  1  transmitter accepts dout when dout_valid & dout_ready (a "beat").
- led  output  8  last byte received via din_valid, in either mode.
- overflow  output  1  sticky; set when an echo byte is dropped.
- fifo_count  output  FIFO_AW+1  bytes currently stored in the FIFO (excludes the output register).

## Operation
- Reset values:
  - dout = 0, dout_valid = 0, led = 0, overflow = 0, fifo_count = 0.
  - Send FSM = IDLE, message index = 0, timer = 0.
- Output register rule:
  - Once dout_valid = 1, dout is held stable until a beat occurs.
  - The output register loads when it is empty or a beat occurs in the same cycle.
- Echo mode (active mode = 0):
  - din_valid pushes din into the FIFO.
  - If the FIFO is full and no pop occurs in the same cycle, the byte is dropped and overflow is set. overflow clears only on rst.
  - Simultaneous push and pop on a full FIFO is accepted; fifo_count is unchanged.
  - The output register pops from the FIFO head whenever it is loadable and fifo_count > 0.
- Send mode (active mode = 1):
  - Timer counts 0..PERIOD-1 and wraps. tick = (timer == PERIOD-1).
  - FSM IDLE: on tick → SEND, index = 0.
  - FSM SEND: presents ROM[index]. Each beat increments the index. A beat at index 14 → IDLE, index = 0.
  - Ticks occurring during SEND are ignored, not queued.
  - din_valid in send mode updates led only; the byte is not pushed.
- Message ROM: 15 bytes, ASCII "Hello, world!" followed by 0x0D, 0x0A.
- Mode switching:
  - The active mode follows the mode input only when no beat is pending (dout_valid = 0, or a beat occurs this cycle).
  - Leaving send mode mid-message aborts the message: FSM = IDLE, index = 0.
  - Timer is held at 0 while the active mode is echo.
  - Entering send mode retains the FIFO contents; they are drained after returning to echo.

## Timing
- Echo, empty FIFO and empty output register:
  - din_valid at cycle N → fifo_count = 1 after edge N.
  - dout_valid = 1 with that byte from cycle N+1; fifo_count returns to 0 at the same time.
- Echo throughput: one byte per cycle while dout_ready = 1.
- Send, with tick at cycle T:
  - dout_valid = 1 with 'H' (0x48) from T+1.
  - With dout_ready held at 1, the 15 bytes occupy T+1..T+15, and dout_valid = 0 at T+16.
  - The next message starts at T+PERIOD+1.
- Stalled transmitter: dout_ready = 0 stretches the message without bound. The timer keeps running; missed ticks are lost.
- rst asserted mid-operation: all state returns to reset values immediately (asynchronous). FIFO contents are discarded.

## Configuration
- ECHO_UPCASE_EN defined:
  - In echo mode, bytes 0x61..0x7A ('a'..'z') are converted to uppercase (minus 0x20) as they enter the output register.
  - led shows the unconverted byte.
- ECHO_UPCASE_EN not defined: echo is byte-exact.
- Send mode is unaffected either way.

## Test plan
- Reset: after rst pulse, all outputs 0. mode = 0, dout_ready = 1, din_valid with 0x41 → dout = 0x41, dout_valid for exactly 1 cycle, led = 0x41.
- Overflow (FIFO_AW = 2, dout_ready = 0): push 6 bytes → 4 in the FIFO + 1 in the output register, fifo_count = 4, overflow = 1. Then dout_ready = 1 → the first 5 bytes are emitted in order.
- Send (PERIOD = 32, dout_ready = 1): "Hello, world!\r\n" (48 65 6C 6C 6F 2C 20 77 6F 72 6C 64 21 0D 0A) appears at T+1..T+15 and again 32 cycles later.
- Backpressure: dout_ready toggling 1/0 in send mode → each byte is held until accepted, with no duplicates or skips.
- Mode switch: set mode = 0 at byte 5 while dout_ready = 0 → 'o' is held until a beat, then the message aborts. The next switch to send restarts at 'H'.
- ECHO_UPCASE_EN: echo 0x61, 0x7A, 0x5B → 0x41, 0x5A, 0x5B. Without the macro → 0x61, 0x7A, 0x5B.
